blc_multi_csr: RTL and testbench
================================

// Module: blc_multi_csr
// PURPOSE
//  AXI4-Lite control/status block for the multi-channel (Bayer) black level calibration datapath.
//  Holds a per-channel manual black level and a mode bit, both double-buffered and applied at frame start.
//  Issues a calibration strobe, tracks busy/done/overrun status and exposes the measured per-channel levels.
//  Sits between the AXI4-Lite interconnect and the BLC datapath.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte base address of the register window
//  CH_CNT     4              number of colour channels (>=1)
//  BL_W       12             black level width in bits (1..32)
// PORTS
//  clk_i          in   1            clock; all logic on the rising edge
//  rst_i          in   1            synchronous reset, active-high
//  csr_aw*/w*/b*  -    AXI4-Lite    write channels: awaddr[31:0], wdata[31:0], wstrb[3:0], bresp[1:0]
//  csr_ar*/r*     -    AXI4-Lite    read channels: araddr[31:0], rdata[31:0], rresp[1:0]
//  sof_i          in   1            start-of-frame pulse from the video stream
//  cal_done_i     in   1            one-cycle pulse from the datapath: calibration finished
//  cur_bl_i       in   CH_CNT*BL_W  measured black level; channel c in [c*BL_W +: BL_W]
//  mode_o         out  1            active mode (0 = auto, 1 = manual)
//  cal_stb_o      out  1            one-cycle calibration start pulse
//  man_bl_o       out  CH_CNT*BL_W  active manual black levels, same packing as cur_bl_i
// BEHAVIOUR
//  Register map (word index = (addr-BASE_ADDR)>>2; TOTAL = 3+2*CH_CNT):
//   0 MODE_CR rw b0 | 1 CAL_STB_CR wo b0, reads 0 | 2 STATUS_SR b0 busy ro, b1 done W1C, b2 ovr W1C
//   3+c MAN_BL_CR[c] rw [BL_W-1:0] | 3+CH_CNT+c CUR_BL_SR[c] ro, zero-extended cur_bl_i
//  Decode error: addr[1:0]!=0, addr<BASE_ADDR, or index>=TOTAL. Writes to ro registers are also errors.
//   An error returns SLVERR (2'b10) and changes no state. Every other access returns OKAY (2'b00).
//  Write path:
//   - AW and W are accepted independently into one-deep holds.
//   - awready = !aw_held && !bvalid. wready = !w_held && !bvalid.
//   - Commit cycle = first cycle with both holds full.
//   - At the end of the commit cycle: the register updates (per wstrb byte), the holds clear, and bvalid rises.
//   - bvalid and bresp stay stable until bready. AW and W in the same cycle N give bvalid in cycle N+2.
//  Read path:
//   - arready = !rvalid.
//   - After an AR handshake in cycle N: rdata/rresp are valid and rvalid=1 in cycle N+1.
//   - Values stay stable until rready. rdata = 0 on error.
//  Staging and activation:
//   - MODE_CR and MAN_BL_CR write staging registers. Reads return the staged values.
//   - On sof_i, mode_o and man_bl_o load from staging.
//   - If a commit coincides with sof_i, the pre-commit staged value is loaded; the new value applies at the next sof_i.
//  Calibration:
//   - Commit of CAL_STB_CR with wdata[0]=1 and wstrb[0]=1 pulses cal_stb_o for one cycle, in the cycle after commit, and sets busy.
//   - If busy is already 1 at that commit, no pulse is issued and ovr is set instead.
//   - cal_done_i clears busy and sets done.
//   - W1C: writing 1 to b1/b2 clears that bit. If a hardware set coincides with the W1C, the set wins.
//  Reset: every register, hold and status bit goes to 0.
//   - Outputs at reset: mode_o=0, cal_stb_o=0, man_bl_o=0, bvalid=0, rvalid=0, rdata=0.
//   - Ready outputs are 1 once reset is low.
//   - Reset mid-transaction drops the transaction silently; no B or R response is issued.
//  Bit widths: MAN_BL_CR bits above BL_W are ignored on write and read back as 0.
// STRUCTURE
//  Package blc_multi_csr_pkg holds:
//   - register index localparams as functions of CH_CNT
//   - STATUS bit positions
//   - RESP_OKAY/RESP_SLVERR
//   - the decode function (index, ro flag, error)
//  One sub-module, axil_reg_if: the AW/W holds, the B/R handshakes and decode.
//   - It presents wr_req/wr_idx/wdata/wstrb and rd_req/rd_idx to the top-level register file.
// TESTING
//  1. MAN_BL_CR[1]=0x3FF written, then sof_i -> man_bl_o[1] is 0x3FF only after sof_i; readback 0x3FF, bresp OKAY.
//  2. AW in cycle 0, W in cycle 3 (bready=0 until cycle 8) -> awready low cycles 1-8, bvalid from cycle 5 held to 8.
//  3. Write CAL_STB_CR=1 twice before cal_done_i -> one cal_stb_o pulse; STATUS reads 0x5; after done and W1C 0x6 -> 0x0.
//  4. Read BASE+4*TOTAL, write CUR_BL_SR[0], awaddr BASE+2 -> SLVERR each time, no register change, rdata=0.
//  5. Commit of MODE_CR=1 in the same cycle as sof_i -> mode_o stays 0; next sof_i -> mode_o=1.
//  6. rst_i asserted with AW held and rvalid=1 -> all outputs return to their reset values next cycle; a following write behaves normally.

Source files
------------

// File: rtl/blc_multi_csr_pkg.sv
// Shared definitions for the black level calibration CSR block.
//  - Register indices (word offsets from the base address), most as functions of CH_CNT
//  - STATUS bit positions and AXI response codes
//  - csr_decode(): maps a byte address to a word index, read-only flag and error flag
package blc_multi_csr_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVR  = 2;

    localparam logic [31:0] IDX_MODE    = 32'd0;
    localparam logic [31:0] IDX_CAL_STB = 32'd1;
    localparam logic [31:0] IDX_STATUS  = 32'd2;
    localparam logic [31:0] IDX_MAN_BL0 = 32'd3;

    // First CUR_BL_SR index; the manual levels occupy the slots before it.
    function automatic logic [31:0] idx_cur_bl0(input int unsigned ch_cnt);
        return IDX_MAN_BL0 + 32'(ch_cnt);
    endfunction

    // Number of implemented words; any index at or beyond this is a decode error.
    function automatic logic [31:0] idx_total(input int unsigned ch_cnt);
        return IDX_MAN_BL0 + 32'(2 * ch_cnt);
    endfunction

    typedef struct packed {
        logic [31:0] idx;
        logic        ro;
        logic        err;
    } csr_dec_t;

    // Only the CUR_BL_SR block is read-only; STATUS accepts W1C writes.
    function automatic csr_dec_t csr_decode(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned ch_cnt,
                                            input logic        is_wr);
        logic [31:0] off;
        csr_dec_t    d;
        off   = addr - base;
        d.idx = {2'b00, off[31:2]};
        d.ro  = (d.idx >= idx_cur_bl0(ch_cnt)) && (d.idx < idx_total(ch_cnt));
        d.err = (addr[1:0] != 2'b00) || (addr < base) ||
                (d.idx >= idx_total(ch_cnt)) || (is_wr && d.ro);
        return d;
    endfunction

endpackage

// File: rtl/axil_reg_if.sv
// AXI4-Lite slave front end for blc_multi_csr.
//  - AW and W each land in a one-deep hold; the first cycle both holds are full is
//    the commit cycle, which presents wr_req (when the decode is clean) and launches B.
//  - AR is decoded in its handshake cycle; rd_idx/rd_req go to the register file,
//    whose combinational rd_data is captured into the R channel.
// Ports: clk_i, rst_i, csr_aw*/w*/b*/ar*/r* (AXI4-Lite), wr_req/wr_idx/wr_data/wr_strb,
//        rd_req/rd_idx (out), rd_data (in).
module axil_reg_if
    import blc_multi_csr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CH_CNT    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] csr_awaddr,
    input  logic        csr_awvalid,
    output logic        csr_awready,
    input  logic [31:0] csr_wdata,
    input  logic [3:0]  csr_wstrb,
    input  logic        csr_wvalid,
    output logic        csr_wready,
    output logic [1:0]  csr_bresp,
    output logic        csr_bvalid,
    input  logic        csr_bready,
    input  logic [31:0] csr_araddr,
    input  logic        csr_arvalid,
    output logic        csr_arready,
    output logic [31:0] csr_rdata,
    output logic [1:0]  csr_rresp,
    output logic        csr_rvalid,
    input  logic        csr_rready,
    output logic        wr_req,
    output logic [31:0] wr_idx,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_strb,
    output logic        rd_req,
    output logic [31:0] rd_idx,
    input  logic [31:0] rd_data
);

    logic        aw_held, w_held;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic        commit, ar_fire;
    csr_dec_t    wr_dec, rd_dec;

    assign csr_awready = !aw_held && !csr_bvalid;
    assign csr_wready  = !w_held && !csr_bvalid;
    assign csr_arready = !csr_rvalid;

    assign commit = aw_held && w_held;
    assign wr_dec = csr_decode(aw_addr_q, BASE_ADDR, CH_CNT, 1'b1);
    assign rd_dec = csr_decode(csr_araddr, BASE_ADDR, CH_CNT, 1'b0);

    assign wr_req  = commit && !wr_dec.err;
    assign wr_idx  = wr_dec.idx;
    assign wr_data = w_data_q;
    assign wr_strb = w_strb_q;

    assign ar_fire = csr_arvalid && csr_arready;
    assign rd_req  = ar_fire && !rd_dec.err;
    assign rd_idx  = rd_dec.idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            csr_bvalid <= 1'b0;
            csr_bresp  <= RESP_OKAY;
            csr_rvalid <= 1'b0;
            csr_rresp  <= RESP_OKAY;
            csr_rdata  <= '0;
        end else begin
            if (csr_awvalid && csr_awready) begin
                aw_held   <= 1'b1;
                aw_addr_q <= csr_awaddr;
            end
            if (csr_wvalid && csr_wready) begin
                w_held   <= 1'b1;
                w_data_q <= csr_wdata;
                w_strb_q <= csr_wstrb;
            end
            // Both readies are low while a hold is full, so the clear never races a new accept.
            if (commit) begin
                aw_held    <= 1'b0;
                w_held     <= 1'b0;
                csr_bvalid <= 1'b1;
                csr_bresp  <= wr_dec.err ? RESP_SLVERR : RESP_OKAY;
            end else if (csr_bvalid && csr_bready) begin
                csr_bvalid <= 1'b0;
            end

            if (ar_fire) begin
                csr_rvalid <= 1'b1;
                csr_rresp  <= rd_dec.err ? RESP_SLVERR : RESP_OKAY;
                csr_rdata  <= rd_dec.err ? 32'h0 : rd_data;
            end else if (csr_rvalid && csr_rready) begin
                csr_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/blc_multi_csr.sv
// Control/status register file for the multi-channel black level calibration datapath.
//  - MODE_CR and MAN_BL_CR[c] are written into staging registers and copied to the
//    active outputs (mode_o, man_bl_o) on sof_i, so a frame never sees a half update.
//  - CAL_STB_CR issues a one-cycle cal_stb_o and tracks busy/done/ovr in STATUS_SR.
//  - CUR_BL_SR[c] reflects cur_bl_i zero-extended.
// Ports: clk_i, rst_i (sync, active-high), csr_* AXI4-Lite slave, sof_i, cal_done_i,
//        cur_bl_i (CH_CNT*BL_W), mode_o, cal_stb_o, man_bl_o (CH_CNT*BL_W).
module blc_multi_csr
    import blc_multi_csr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CH_CNT    = 4,
    parameter int          BL_W      = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [31:0]            csr_awaddr,
    input  logic                   csr_awvalid,
    output logic                   csr_awready,
    input  logic [31:0]            csr_wdata,
    input  logic [3:0]             csr_wstrb,
    input  logic                   csr_wvalid,
    output logic                   csr_wready,
    output logic [1:0]             csr_bresp,
    output logic                   csr_bvalid,
    input  logic                   csr_bready,
    input  logic [31:0]            csr_araddr,
    input  logic                   csr_arvalid,
    output logic                   csr_arready,
    output logic [31:0]            csr_rdata,
    output logic [1:0]             csr_rresp,
    output logic                   csr_rvalid,
    input  logic                   csr_rready,
    input  logic                   sof_i,
    input  logic                   cal_done_i,
    input  logic [CH_CNT*BL_W-1:0] cur_bl_i,
    output logic                   mode_o,
    output logic                   cal_stb_o,
    output logic [CH_CNT*BL_W-1:0] man_bl_o
);

    logic        wr_req, rd_req;
    logic [31:0] wr_idx, wr_data, rd_idx, rd_data;
    logic [3:0]  wr_strb;
    logic [31:0] wmask;

    logic mode_stg, mode_q;
    logic busy_q, done_q, ovr_q, cal_stb_q;
    logic cal_go, st_w1c;

    logic [CH_CNT-1:0][BL_W-1:0] man_stg, man_act, cur_bl;

    axil_reg_if #(
        .BASE_ADDR (BASE_ADDR),
        .CH_CNT    (CH_CNT)
    ) u_if (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .csr_awaddr  (csr_awaddr),
        .csr_awvalid (csr_awvalid),
        .csr_awready (csr_awready),
        .csr_wdata   (csr_wdata),
        .csr_wstrb   (csr_wstrb),
        .csr_wvalid  (csr_wvalid),
        .csr_wready  (csr_wready),
        .csr_bresp   (csr_bresp),
        .csr_bvalid  (csr_bvalid),
        .csr_bready  (csr_bready),
        .csr_araddr  (csr_araddr),
        .csr_arvalid (csr_arvalid),
        .csr_arready (csr_arready),
        .csr_rdata   (csr_rdata),
        .csr_rresp   (csr_rresp),
        .csr_rvalid  (csr_rvalid),
        .csr_rready  (csr_rready),
        .wr_req      (wr_req),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .wr_strb     (wr_strb),
        .rd_req      (rd_req),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data)
    );

    assign wmask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};

    assign cur_bl    = cur_bl_i;
    assign man_bl_o  = man_act;
    assign mode_o    = mode_q;
    assign cal_stb_o = cal_stb_q;

    assign cal_go = wr_req && (wr_idx == IDX_CAL_STB) && wr_strb[0] && wr_data[0];
    assign st_w1c = wr_req && (wr_idx == IDX_STATUS) && wr_strb[0];

    // Mode: staged on write, activated on sof_i. Nonblocking semantics mean a commit
    // coinciding with sof_i activates the pre-commit staged value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_stg <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            if (wr_req && (wr_idx == IDX_MODE) && wr_strb[0])
                mode_stg <= wr_data[0];
            if (sof_i)
                mode_q <= mode_stg;
        end
    end

    // Per-channel manual level: byte-lane merge into the staged value, then sof_i copy.
    for (genvar c = 0; c < CH_CNT; c++) begin : g_ch
        logic [31:0]     man_ext, man_nxt;
        logic [BL_W-1:0] stg_q, act_q;

        always_comb begin
            man_ext             = '0;
            man_ext[BL_W-1:0]   = stg_q;
            man_nxt             = (man_ext & ~wmask) | (wr_data & wmask);
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stg_q <= '0;
                act_q <= '0;
            end else begin
                if (wr_req && (wr_idx == IDX_MAN_BL0 + 32'(c)))
                    stg_q <= man_nxt[BL_W-1:0];
                if (sof_i)
                    act_q <= stg_q;
            end
        end

        assign man_stg[c] = stg_q;
        assign man_act[c] = act_q;
    end

    // Calibration control. A start while busy is dropped and flagged as overrun.
    // Hardware sets take priority over a coincident W1C.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            cal_stb_q <= 1'b0;
        end else begin
            cal_stb_q <= cal_go && !busy_q;

            if (cal_go && !busy_q)
                busy_q <= 1'b1;
            else if (cal_done_i)
                busy_q <= 1'b0;

            if (cal_done_i)
                done_q <= 1'b1;
            else if (st_w1c && wr_data[ST_DONE])
                done_q <= 1'b0;

            if (cal_go && busy_q)
                ovr_q <= 1'b1;
            else if (st_w1c && wr_data[ST_OVR])
                ovr_q <= 1'b0;
        end
    end

    // Read mux; MODE and MAN_BL return staged values, CAL_STB_CR reads as zero.
    always_comb begin
        rd_data = '0;
        if (rd_req) begin
            if (rd_idx == IDX_MODE)
                rd_data[0] = mode_stg;
            if (rd_idx == IDX_STATUS) begin
                rd_data[ST_BUSY] = busy_q;
                rd_data[ST_DONE] = done_q;
                rd_data[ST_OVR]  = ovr_q;
            end
            for (int c = 0; c < CH_CNT; c++) begin
                if (rd_idx == IDX_MAN_BL0 + 32'(c))
                    rd_data[BL_W-1:0] = man_stg[c];
                if (rd_idx == idx_cur_bl0(CH_CNT) + 32'(c))
                    rd_data[BL_W-1:0] = cur_bl[c];
            end
        end
    end

endmodule

// File: tb/tb_blc_multi_csr.sv
// Directed bench for blc_multi_csr (BASE_ADDR=0x100, CH_CNT=4, BL_W=12).
// Map: MODE 0x100, CAL 0x104, STATUS 0x108, MAN_BL 0x10C..0x118, CUR_BL 0x11C..0x128.
module tb_blc_multi_csr;

    localparam logic [31:0] BASE = 32'h100;
    localparam int CH = 4;
    localparam int BW = 12;

    logic clk_i = 1'b0;
    logic rst_i;
    logic [31:0] csr_awaddr, csr_wdata, csr_araddr, csr_rdata;
    logic csr_awvalid, csr_awready, csr_wvalid, csr_wready, csr_bvalid, csr_bready;
    logic csr_arvalid, csr_arready, csr_rvalid, csr_rready;
    logic [3:0] csr_wstrb;
    logic [1:0] csr_bresp, csr_rresp;
    logic sof_i, cal_done_i, mode_o, cal_stb_o;
    logic [CH*BW-1:0] cur_bl_i, man_bl_o;

    int tests = 0;
    int fails = 0;
    int stb_cnt = 0;

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (cal_stb_o === 1'b1) stb_cnt++;

    blc_multi_csr #(.BASE_ADDR(BASE), .CH_CNT(CH), .BL_W(BW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .csr_awaddr(csr_awaddr), .csr_awvalid(csr_awvalid), .csr_awready(csr_awready),
        .csr_wdata(csr_wdata), .csr_wstrb(csr_wstrb), .csr_wvalid(csr_wvalid),
        .csr_wready(csr_wready), .csr_bresp(csr_bresp), .csr_bvalid(csr_bvalid),
        .csr_bready(csr_bready), .csr_araddr(csr_araddr), .csr_arvalid(csr_arvalid),
        .csr_arready(csr_arready), .csr_rdata(csr_rdata), .csr_rresp(csr_rresp),
        .csr_rvalid(csr_rvalid), .csr_rready(csr_rready),
        .sof_i(sof_i), .cal_done_i(cal_done_i), .cur_bl_i(cur_bl_i),
        .mode_o(mode_o), .cal_stb_o(cal_stb_o), .man_bl_o(man_bl_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives AW and W together, waits for B; all decisions taken at negedges.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_f, w_f, done;
        done = 1'b0;
        resp = 2'bxx;
        @(negedge clk_i);
        csr_awaddr = addr; csr_awvalid = 1'b1;
        csr_wdata = data; csr_wstrb = strb; csr_wvalid = 1'b1;
        csr_bready = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            aw_f = csr_awvalid && csr_awready;
            w_f  = csr_wvalid && csr_wready;
            if (csr_bvalid) begin resp = csr_bresp; done = 1'b1; end
            @(negedge clk_i);
            if (aw_f) csr_awvalid = 1'b0;
            if (w_f)  csr_wvalid = 1'b0;
        end
        csr_awvalid = 1'b0; csr_wvalid = 1'b0; csr_bready = 1'b0;
        check("wr_complete", {63'd0, done}, 64'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        logic ar_f, done;
        done = 1'b0;
        data = 'x; resp = 2'bxx;
        @(negedge clk_i);
        csr_araddr = addr; csr_arvalid = 1'b1; csr_rready = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            ar_f = csr_arvalid && csr_arready;
            if (csr_rvalid) begin data = csr_rdata; resp = csr_rresp; done = 1'b1; end
            @(negedge clk_i);
            if (ar_f) csr_arvalid = 1'b0;
        end
        csr_arvalid = 1'b0; csr_rready = 1'b0;
        check("rd_complete", {63'd0, done}, 64'd1);
    endtask

    task automatic pulse_sof();
        @(negedge clk_i); sof_i = 1'b1;
        @(negedge clk_i); sof_i = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk_i); cal_done_i = 1'b1;
        @(negedge clk_i); cal_done_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        int snap;

        rst_i = 1'b1;
        csr_awaddr = '0; csr_awvalid = 0; csr_wdata = '0; csr_wstrb = '0; csr_wvalid = 0;
        csr_bready = 0; csr_araddr = '0; csr_arvalid = 0; csr_rready = 0;
        sof_i = 0; cal_done_i = 0;
        cur_bl_i = {12'hDDD, 12'hCCC, 12'hBBB, 12'hAAA};
        repeat (3) @(negedge clk_i);
        check("rst_mode", {63'd0, mode_o}, 64'd0);
        check("rst_man", {16'd0, man_bl_o}, 64'd0);
        check("rst_stb", {63'd0, cal_stb_o}, 64'd0);
        check("rst_bvalid", {63'd0, csr_bvalid}, 64'd0);
        check("rst_rvalid", {63'd0, csr_rvalid}, 64'd0);
        check("rst_rdata", {32'd0, csr_rdata}, 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_readies", {61'd0, csr_awready, csr_wready, csr_arready}, 64'd7);

        // 1: staged manual level, activation on sof, byte strobes, upper bits dropped
        axi_write(BASE + 32'h10, 32'h0000_03FF, 4'hF, r);
        check("t1_bresp", {62'd0, r}, 64'd0);
        check("t1_pre_sof", {16'd0, man_bl_o}, 64'd0);
        axi_read(BASE + 32'h10, d, r);
        check("t1_readback", {32'd0, d}, 64'h3FF);
        pulse_sof();
        check("t1_post_sof", {16'd0, man_bl_o}, 64'h0000_003F_F000);
        axi_write(BASE + 32'h14, 32'hFFFF_FABC, 4'b0001, r);
        axi_read(BASE + 32'h14, d, r);
        check("t1_strb0", {32'd0, d}, 64'h0BC);
        axi_write(BASE + 32'h14, 32'hFFFF_FA00, 4'b0010, r);
        axi_read(BASE + 32'h14, d, r);
        check("t1_strb1_trunc", {32'd0, d}, 64'hABC);

        // 2: AW in cycle 0, W in cycle 3, bready from cycle 8
        @(negedge clk_i);
        csr_awaddr = BASE + 32'h0C; csr_awvalid = 1'b1; csr_bready = 1'b0;
        check("t2_c0_awready", {63'd0, csr_awready}, 64'd1);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk_i);
            if (c == 1) csr_awvalid = 1'b0;
            if (c == 3) begin
                check("t2_c3_wready", {63'd0, csr_wready}, 64'd1);
                csr_wdata = 32'h123; csr_wstrb = 4'hF; csr_wvalid = 1'b1;
            end
            if (c == 4) csr_wvalid = 1'b0;
            if (c == 5) check("t2_bresp", {62'd0, csr_bresp}, 64'd0);
            if (c == 8) csr_bready = 1'b1;
            if (c == 9) csr_bready = 1'b0;
            check($sformatf("t2_c%0d_awready", c), {63'd0, csr_awready},
                  (c >= 1 && c <= 8) ? 64'd0 : 64'd1);
            check($sformatf("t2_c%0d_bvalid", c), {63'd0, csr_bvalid},
                  (c >= 5 && c <= 8) ? 64'd1 : 64'd0);
        end

        // 3: calibration strobe, overrun, done, W1C
        snap = stb_cnt;
        axi_write(BASE + 32'h04, 32'h1, 4'hF, r);
        axi_write(BASE + 32'h04, 32'h1, 4'hF, r);
        check("t3_one_pulse", 64'(stb_cnt - snap), 64'd1);
        axi_read(BASE + 32'h08, d, r);
        check("t3_status_busy_ovr", {32'd0, d}, 64'h5);
        pulse_done();
        axi_read(BASE + 32'h08, d, r);
        check("t3_status_done_ovr", {32'd0, d}, 64'h6);
        axi_write(BASE + 32'h08, 32'h6, 4'hF, r);
        axi_read(BASE + 32'h08, d, r);
        check("t3_status_w1c", {32'd0, d}, 64'h0);
        pulse_done();
        // W1C of done committed in the same cycle as cal_done_i: set wins
        @(negedge clk_i);
        csr_awaddr = BASE + 32'h08; csr_awvalid = 1'b1;
        csr_wdata = 32'h2; csr_wstrb = 4'hF; csr_wvalid = 1'b1; csr_bready = 1'b1;
        @(negedge clk_i);
        csr_awvalid = 1'b0; csr_wvalid = 1'b0; cal_done_i = 1'b1;
        @(negedge clk_i);
        cal_done_i = 1'b0;
        check("t3_race_bvalid", {63'd0, csr_bvalid}, 64'd1);
        @(negedge clk_i);
        csr_bready = 1'b0;
        axi_read(BASE + 32'h08, d, r);
        check("t3_set_wins", {32'd0, d}, 64'h2);

        // 4: decode errors
        axi_read(BASE + 32'h2C, d, r);
        check("t4_rd_oob_resp", {62'd0, r}, 64'd2);
        check("t4_rd_oob_data", {32'd0, d}, 64'd0);
        axi_read(BASE - 32'h4, d, r);
        check("t4_rd_below_resp", {62'd0, r}, 64'd2);
        axi_write(BASE + 32'h1C, 32'h555, 4'hF, r);
        check("t4_wr_ro_resp", {62'd0, r}, 64'd2);
        axi_write(BASE + 32'h02, 32'h1, 4'hF, r);
        check("t4_wr_unaligned", {62'd0, r}, 64'd2);
        axi_read(BASE, d, r);
        check("t4_mode_unchanged", {30'd0, r, d}, 64'd0);
        axi_read(BASE + 32'h24, d, r);
        check("t4_cur_bl2", {30'd0, r, d}, 64'hCCC);
        axi_read(BASE + 32'h04, d, r);
        check("t4_cal_reads0", {30'd0, r, d}, 64'd0);

        // 5: MODE commit coinciding with sof
        @(negedge clk_i);
        csr_awaddr = BASE; csr_awvalid = 1'b1;
        csr_wdata = 32'h1; csr_wstrb = 4'hF; csr_wvalid = 1'b1; csr_bready = 1'b1;
        @(negedge clk_i);
        csr_awvalid = 1'b0; csr_wvalid = 1'b0; sof_i = 1'b1;
        @(negedge clk_i);
        sof_i = 1'b0;
        check("t5_mode_held", {63'd0, mode_o}, 64'd0);
        @(negedge clk_i);
        csr_bready = 1'b0;
        pulse_sof();
        check("t5_mode_next_sof", {63'd0, mode_o}, 64'd1);
        check("t5_man_all", {16'd0, man_bl_o}, 64'h0000_0ABC_3FF1_23);

        // 6: reset with AW held and rvalid high
        @(negedge clk_i);
        csr_awaddr = BASE; csr_awvalid = 1'b1; csr_araddr = BASE + 32'h10;
        csr_arvalid = 1'b1; csr_rready = 1'b0;
        @(negedge clk_i);
        csr_awvalid = 1'b0; csr_arvalid = 1'b0;
        check("t6_pre_rvalid", {63'd0, csr_rvalid}, 64'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("t6_mode", {63'd0, mode_o}, 64'd0);
        check("t6_man", {16'd0, man_bl_o}, 64'd0);
        check("t6_valids", {62'd0, csr_bvalid, csr_rvalid}, 64'd0);
        check("t6_rdata", {32'd0, csr_rdata}, 64'd0);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("t6_no_bvalid", {63'd0, csr_bvalid}, 64'd0);
        axi_write(BASE + 32'h18, 32'h777, 4'hF, r);
        check("t6_wr_resp", {62'd0, r}, 64'd0);
        axi_read(BASE + 32'h18, d, r);
        check("t6_readback", {30'd0, r, d}, 64'h777);
        axi_read(BASE, d, r);
        check("t6_mode_cleared", {30'd0, r, d}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
